// File: rtl/hazard_pkg.sv
// Shared definitions for the scoreboard-based hazard unit.
//   state_t       : issue FSM state (PAIR = both slots pending, S1_ONLY = slot 0 done)
//   DEF_*         : default register-file geometry and latencies
//   calc_cnt_w()  : width of one per-register countdown counter
package hazard_pkg;

    typedef enum logic {
        PAIR    = 1'b0,
        S1_ONLY = 1'b1
    } state_t;

    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_REG_W      = 3;
    localparam int DEF_ALU_LAT    = 0;
    localparam int DEF_LOAD_LAT   = 1;
    localparam int DEF_BR_PENALTY = 1;

    // Wide enough to hold the largest value ever loaded: max latency + branch penalty.
    function automatic int calc_cnt_w(input int alu_lat, input int load_lat, input int br_penalty);
        int m;
        int w;
        m = (alu_lat > load_lat) ? alu_lat : load_lat;
        w = $clog2(m + br_penalty + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: counts down to zero and holds there; a load takes the
// larger of the loaded value and the already-decremented count.
//   clk, reset : clock, asynchronous active-high reset
//   load       : an instruction writing this register issues this cycle
//   load_val   : cycles until the result is forwardable to the ID branch comparator
//   cnt        : current count (0 = no write in flight)
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt
);

    logic [W-1:0] dec;

    assign dec = (cnt == '0) ? '0 : cnt - 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            // Max keeps an older, longer-latency write from being shortened.
            cnt <= (load_val > dec) ? load_val : dec;
        end else begin
            cnt <= dec;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Dual-issue ID-stage hazard unit driven by a per-register countdown scoreboard.
// A dependent pair is split over two issue cycles by a two-state FSM.
//   id_*        : decoded fields of the two slots held in IF/ID
//   flush       : squash IF/ID this cycle (taken branch)
//   pc_write    : PC may advance;  if_id_write : IF/ID may load
//   cntrl_sel0/1: 1 = bubble into that slot's ID/EX control
//   busy_vec    : per-register "write in flight" flags
//   stall_count : saturating count of cycles with pc_write=0
//   dbg_state   : current issue FSM state
// Handshake: the IF/ID pair is consumed on a cycle where pc_write=1; a slot has
// issued on a cycle where its cntrl_sel is 0.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int REG_W      = DEF_REG_W,
    parameter int ALU_LAT    = DEF_ALU_LAT,
    parameter int LOAD_LAT   = DEF_LOAD_LAT,
    parameter int BR_PENALTY = DEF_BR_PENALTY
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid0,
    input  logic                id_valid1,
    input  logic [REG_W-1:0]    id_rd0,
    input  logic [REG_W-1:0]    id_rn0,
    input  logic [REG_W-1:0]    id_rm0,
    input  logic [REG_W-1:0]    id_rd1,
    input  logic [REG_W-1:0]    id_rn1,
    input  logic [REG_W-1:0]    id_rm1,
    input  logic                id_uses_rn0,
    input  logic                id_uses_rm0,
    input  logic                id_uses_rn1,
    input  logic                id_uses_rm1,
    input  logic                id_regwrite0,
    input  logic                id_regwrite1,
    input  logic                id_memread0,
    input  logic                id_memread1,
    input  logic                id_branch0,
    input  logic                flush,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                cntrl_sel0,
    output logic                cntrl_sel1,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [15:0]         stall_count,
    output state_t              dbg_state
);

    localparam int CNT_W = calc_cnt_w(ALU_LAT, LOAD_LAT, BR_PENALTY);
    localparam int TBL   = 2 ** REG_W;
    localparam logic [CNT_W-1:0] BR_P   = CNT_W'(BR_PENALTY);
    localparam logic [CNT_W-1:0] ALU_V  = CNT_W'(ALU_LAT + BR_PENALTY);
    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_LAT + BR_PENALTY);

    state_t state, state_next;
    logic   issue0, issue1;
    logic   v0, blk0, blk1, dep1;
    logic [CNT_W-1:0] thr0;
    logic [CNT_W-1:0] lat0, lat1;

    // Indexed by the full address space; unimplemented registers read as idle.
    logic [CNT_W-1:0] cnt_tbl [TBL];

    assign lat0 = id_memread0 ? LOAD_V : ALU_V;
    assign lat1 = id_memread1 ? LOAD_V : ALU_V;

    genvar r;
    generate
        for (r = 0; r < TBL; r++) begin : g_reg
            if (r < NUM_REGS) begin : g_cnt
                logic hit0, hit1;
                assign hit0 = issue0 && id_regwrite0 && (id_rd0 == REG_W'(r));
                assign hit1 = issue1 && id_regwrite1 && (id_rd1 == REG_W'(r));
                // Slot 1 is younger, so its latency wins on a same-rd pair.
                sb_counter #(.W(CNT_W)) u_cnt (
                    .clk      (clk),
                    .reset    (reset),
                    .load     (hit0 | hit1),
                    .load_val (hit1 ? lat1 : lat0),
                    .cnt      (cnt_tbl[r])
                );
                assign busy_vec[r] = |cnt_tbl[r];
            end else begin : g_pad
                assign cnt_tbl[r] = '0;
            end
        end
    endgenerate

    // Slot 0 has already left in S1_ONLY, so it neither blocks nor feeds slot 1.
    assign v0   = id_valid0 && (state == PAIR);
    // Branches compare in ID and need the value BR_PENALTY cycles earlier than EX.
    assign thr0 = id_branch0 ? '0 : BR_P;
    assign blk0 = v0 && ((id_uses_rn0 && (cnt_tbl[id_rn0] > thr0)) ||
                         (id_uses_rm0 && (cnt_tbl[id_rm0] > thr0)));
    assign dep1 = v0 && id_regwrite0 &&
                  ((id_uses_rn1 && (id_rd0 == id_rn1)) || (id_uses_rm1 && (id_rd0 == id_rm1)));
    assign blk1 = id_valid1 && (dep1 ||
                  (id_uses_rn1 && (cnt_tbl[id_rn1] > BR_P)) ||
                  (id_uses_rm1 && (cnt_tbl[id_rm1] > BR_P)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PAIR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        issue0      = 1'b0;
        issue1      = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if (flush) begin
            state_next = PAIR;
        end else begin
            case (state)
                PAIR: begin
                    if (blk0) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                    end else if (blk1) begin
                        issue0      = v0;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        state_next  = S1_ONLY;
                    end else begin
                        issue0 = v0;
                        issue1 = id_valid1;
                    end
                end
                S1_ONLY: begin
                    if (blk1) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                    end else begin
                        issue1     = id_valid1;
                        state_next = PAIR;
                    end
                end
                default: state_next = PAIR;
            endcase
        end
    end

    assign cntrl_sel0 = ~issue0;
    assign cntrl_sel1 = ~issue1;
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    typedef struct {
        logic       v;
        logic [2:0] rd, rn, rm;
        logic       urn, urm, rw, mr;
    } ins_t;

    typedef struct {
        ins_t        s0, s1;
        logic        br, fl;
        logic        pcw, sel0, sel1;
        logic [7:0]  busy;
        logic [15:0] stall;
        state_t      st;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       id_valid0 = 0, id_valid1 = 0;
    logic [2:0] id_rd0 = 0, id_rn0 = 0, id_rm0 = 0, id_rd1 = 0, id_rn1 = 0, id_rm1 = 0;
    logic       id_uses_rn0 = 0, id_uses_rm0 = 0, id_uses_rn1 = 0, id_uses_rm1 = 0;
    logic       id_regwrite0 = 0, id_regwrite1 = 0, id_memread0 = 0, id_memread1 = 0;
    logic       id_branch0 = 0, flush = 0;

    logic        pcw_a, ifw_a, sel0_a, sel1_a;
    logic [7:0]  busy_a;
    logic [15:0] stall_a;
    state_t      st_a;
    logic        pcw_b, ifw_b, sel0_b, sel1_b;
    logic [7:0]  busy_b;
    logic [15:0] stall_b;
    state_t      st_b;

    hazard_scoreboard dut_a (
        .clk(clk), .reset(reset),
        .id_valid0(id_valid0), .id_valid1(id_valid1),
        .id_rd0(id_rd0), .id_rn0(id_rn0), .id_rm0(id_rm0),
        .id_rd1(id_rd1), .id_rn1(id_rn1), .id_rm1(id_rm1),
        .id_uses_rn0(id_uses_rn0), .id_uses_rm0(id_uses_rm0),
        .id_uses_rn1(id_uses_rn1), .id_uses_rm1(id_uses_rm1),
        .id_regwrite0(id_regwrite0), .id_regwrite1(id_regwrite1),
        .id_memread0(id_memread0), .id_memread1(id_memread1),
        .id_branch0(id_branch0), .flush(flush),
        .pc_write(pcw_a), .if_id_write(ifw_a), .cntrl_sel0(sel0_a), .cntrl_sel1(sel1_a),
        .busy_vec(busy_a), .stall_count(stall_a), .dbg_state(st_a)
    );

    hazard_scoreboard #(.LOAD_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .id_valid0(id_valid0), .id_valid1(id_valid1),
        .id_rd0(id_rd0), .id_rn0(id_rn0), .id_rm0(id_rm0),
        .id_rd1(id_rd1), .id_rn1(id_rn1), .id_rm1(id_rm1),
        .id_uses_rn0(id_uses_rn0), .id_uses_rm0(id_uses_rm0),
        .id_uses_rn1(id_uses_rn1), .id_uses_rm1(id_uses_rm1),
        .id_regwrite0(id_regwrite0), .id_regwrite1(id_regwrite1),
        .id_memread0(id_memread0), .id_memread1(id_memread1),
        .id_branch0(id_branch0), .flush(flush),
        .pc_write(pcw_b), .if_id_write(ifw_b), .cntrl_sel0(sel0_b), .cntrl_sel1(sel1_b),
        .busy_vec(busy_b), .stall_count(stall_b), .dbg_state(st_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard check
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic ins_t nop_i();
        ins_t i;
        i = '{v: 1'b0, rd: 3'd0, rn: 3'd0, rm: 3'd0, urn: 1'b0, urm: 1'b0, rw: 1'b0, mr: 1'b0};
        return i;
    endfunction

    function automatic ins_t alu_i(input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
        ins_t i;
        i = '{v: 1'b1, rd: rd, rn: rn, rm: rm, urn: 1'b1, urm: 1'b1, rw: 1'b1, mr: 1'b0};
        return i;
    endfunction

    function automatic ins_t ld_i(input logic [2:0] rd, input logic [2:0] rn);
        ins_t i;
        i = '{v: 1'b1, rd: rd, rn: rn, rm: 3'd0, urn: 1'b1, urm: 1'b0, rw: 1'b1, mr: 1'b1};
        return i;
    endfunction

    function automatic ins_t br_i(input logic [2:0] rn, input logic [2:0] rm);
        ins_t i;
        i = '{v: 1'b1, rd: 3'd0, rn: rn, rm: rm, urn: 1'b1, urm: 1'b1, rw: 1'b0, mr: 1'b0};
        return i;
    endfunction

    function automatic vec_t mkv(input ins_t s0, input ins_t s1, input logic br, input logic fl,
                                 input logic pcw, input logic sel0, input logic sel1,
                                 input logic [7:0] busy, input logic [15:0] stall, input state_t st);
        vec_t v;
        v = '{s0: s0, s1: s1, br: br, fl: fl, pcw: pcw, sel0: sel0, sel1: sel1,
              busy: busy, stall: stall, st: st};
        return v;
    endfunction

    // driver tasks
    task automatic drive(input ins_t s0, input ins_t s1, input logic br, input logic fl);
        id_valid0 = s0.v; id_rd0 = s0.rd; id_rn0 = s0.rn; id_rm0 = s0.rm;
        id_uses_rn0 = s0.urn; id_uses_rm0 = s0.urm; id_regwrite0 = s0.rw; id_memread0 = s0.mr;
        id_valid1 = s1.v; id_rd1 = s1.rd; id_rn1 = s1.rn; id_rm1 = s1.rm;
        id_uses_rn1 = s1.urn; id_uses_rm1 = s1.urm; id_regwrite1 = s1.rw; id_memread1 = s1.mr;
        id_branch0 = br;
        flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(nop_i(), nop_i(), 1'b0, 1'b0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic pcw, input logic sel0, input logic sel1,
                         input logic [7:0] busy, input logic [15:0] stall, input state_t st);
        chk({tag, " pc_write"}, 32'(pcw_a), 32'(pcw));
        chk({tag, " if_id_write"}, 32'(ifw_a), 32'(pcw));
        chk({tag, " cntrl_sel0"}, 32'(sel0_a), 32'(sel0));
        chk({tag, " cntrl_sel1"}, 32'(sel1_a), 32'(sel1));
        chk({tag, " busy_vec"}, 32'(busy_a), 32'(busy));
        chk({tag, " stall_count"}, 32'(stall_a), 32'(stall));
        chk({tag, " state"}, 32'(st_a), 32'(st));
    endtask

    vec_t tbl[14];

    initial begin
        // default-latency instance, vectors run back to back from reset
        tbl[0]  = mkv(ld_i(3'd2, 3'd0),         nop_i(), 0, 0, 1, 0, 1, 8'h00, 16'd0, PAIR);
        tbl[1]  = mkv(alu_i(3'd4, 3'd1, 3'd2),  nop_i(), 0, 0, 0, 1, 1, 8'h04, 16'd0, PAIR);
        tbl[2]  = mkv(alu_i(3'd4, 3'd1, 3'd2),  nop_i(), 0, 0, 1, 0, 1, 8'h04, 16'd1, PAIR);
        tbl[3]  = mkv(alu_i(3'd5, 3'd6, 3'd7), alu_i(3'd1, 3'd5, 3'd0), 0, 0, 0, 0, 1, 8'h10, 16'd1, PAIR);
        tbl[4]  = mkv(alu_i(3'd5, 3'd6, 3'd7), alu_i(3'd1, 3'd5, 3'd0), 0, 0, 1, 1, 0, 8'h20, 16'd2, S1_ONLY);
        tbl[5]  = mkv(alu_i(3'd3, 3'd0, 3'd0),  nop_i(), 0, 0, 1, 0, 1, 8'h02, 16'd2, PAIR);
        tbl[6]  = mkv(br_i(3'd3, 3'd0),         nop_i(), 1, 0, 0, 1, 1, 8'h08, 16'd2, PAIR);
        tbl[7]  = mkv(br_i(3'd3, 3'd0),         nop_i(), 1, 0, 1, 0, 1, 8'h00, 16'd3, PAIR);
        tbl[8]  = mkv(alu_i(3'd3, 3'd0, 3'd0),  nop_i(), 0, 0, 1, 0, 1, 8'h00, 16'd3, PAIR);
        tbl[9]  = mkv(alu_i(3'd6, 3'd3, 3'd3),  nop_i(), 0, 0, 1, 0, 1, 8'h08, 16'd3, PAIR);
        tbl[10] = mkv(nop_i(),                  nop_i(), 0, 0, 1, 1, 1, 8'h40, 16'd3, PAIR);
        tbl[11] = mkv(ld_i(3'd7, 3'd0), alu_i(3'd7, 3'd0, 3'd0), 0, 0, 1, 0, 0, 8'h00, 16'd3, PAIR);
        tbl[12] = mkv(nop_i(),                  nop_i(), 0, 0, 1, 1, 1, 8'h80, 16'd3, PAIR);
        tbl[13] = mkv(nop_i(),                  nop_i(), 0, 0, 1, 1, 1, 8'h00, 16'd3, PAIR);

        do_reset();
        #3;
        chk_a("reset", 1'b1, 1'b1, 1'b1, 8'h00, 16'd0, PAIR);
        next_cycle();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].s0, tbl[i].s1, tbl[i].br, tbl[i].fl);
            #3;
            chk_a($sformatf("v%0d", i), tbl[i].pcw, tbl[i].sel0, tbl[i].sel1,
                  tbl[i].busy, tbl[i].stall, tbl[i].st);
            next_cycle();
        end

        // flush while holding slot 1 of a split pair
        do_reset();
        drive(ld_i(3'd4, 3'd0), alu_i(3'd1, 3'd4, 3'd0), 1'b0, 1'b0);
        #3;
        chk_a("fl_split", 1'b0, 1'b0, 1'b1, 8'h00, 16'd0, PAIR);
        next_cycle();
        flush = 1'b1;
        #3;
        chk_a("fl_flush", 1'b1, 1'b1, 1'b1, 8'h10, 16'd1, S1_ONLY);
        next_cycle();
        drive(nop_i(), nop_i(), 1'b0, 1'b0);
        #3;
        chk_a("fl_after", 1'b1, 1'b1, 1'b1, 8'h10, 16'd1, PAIR);
        next_cycle();

        // asynchronous reset in the middle of an S1_ONLY stall
        do_reset();
        drive(ld_i(3'd4, 3'd0), alu_i(3'd1, 3'd4, 3'd0), 1'b0, 1'b0);
        next_cycle();
        #3;
        chk_a("rs_stall", 1'b0, 1'b1, 1'b1, 8'h10, 16'd1, S1_ONLY);
        drive(nop_i(), nop_i(), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk_a("rs_async", 1'b1, 1'b1, 1'b1, 8'h00, 16'd0, PAIR);
        next_cycle();
        reset = 1'b0;

        // LOAD_LAT=3 instance: three stall cycles, r1 busy for four
        do_reset();
        drive(ld_i(3'd1, 3'd0), nop_i(), 1'b0, 1'b0);
        #3;
        chk("ll issue pc_write", 32'(pcw_b), 32'd1);
        next_cycle();
        drive(alu_i(3'd2, 3'd1, 3'd0), nop_i(), 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #3;
            chk($sformatf("ll c%0d pc_write", c), 32'(pcw_b), (c < 3) ? 32'd0 : 32'd1);
            chk($sformatf("ll c%0d busy1", c), 32'(busy_b[1]), 32'd1);
            chk($sformatf("ll c%0d cntrl_sel0", c), 32'(sel0_b), (c < 3) ? 32'd1 : 32'd0);
            chk($sformatf("ll c%0d stall_count", c), 32'(stall_b), 32'(c));
            next_cycle();
        end
        drive(nop_i(), nop_i(), 1'b0, 1'b0);
        #3;
        chk("ll end busy1", 32'(busy_b[1]), 32'd0);
        chk("ll end stall_count", 32'(stall_b), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, stateful successor to the dual-slot combinational hazard detector.
- Keeps a per-register countdown scoreboard of in-flight writes and decides stalls from it, instead of from fixed pipeline-stage comparisons.
- Splits a dependent pair into two issue cycles with a small FSM, supports a configurable load/ALU/branch latency, and counts stall cycles.
- Sits in ID, between the IF/ID register and the ID/EX control mux.

Parameters:
- NUM_REGS, 8, number of architectural registers.
- REG_W, 3, register address width; must satisfy 2**REG_W >= NUM_REGS.
- ALU_LAT, 0, cycles before an ALU result can be forwarded to EX.
- LOAD_LAT, 1, cycles before a load result can be forwarded to EX.
- BR_PENALTY, 1, extra cycles before a result can be forwarded to the ID-stage branch comparator.
- CNT_W, derived, clog2(max(ALU_LAT,LOAD_LAT)+BR_PENALTY+1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid0, id_valid1  in  1  slot instruction valid.
- id_rd0, id_rn0, id_rm0, id_rd1, id_rn1, id_rm1  in  REG_W  slot register fields.
- id_uses_rn0, id_uses_rm0, id_uses_rn1, id_uses_rm1  in  1  source field is actually read.
- id_regwrite0, id_regwrite1  in  1  slot writes id_rdN.
- id_memread0, id_memread1  in  1  slot is a load.
- id_branch0  in  1  slot 0 is a branch resolved in ID (slot 1 never branches).
- flush  in  1  squash the IF/ID contents this cycle (taken branch).
- pc_write  out  1  PC may advance.
- if_id_write  out  1  IF/ID may load.
- cntrl_sel0, cntrl_sel1  out  1  1 = inject a bubble into that slot's ID/EX control.
- busy_vec  out  NUM_REGS  bit r = cnt[r]!=0.
- stall_count  out  16  saturating count of cycles with pc_write=0.

Behaviour:
- Scoreboard: cnt[r] of CNT_W bits per register. Every cycle each nonzero cnt decrements by 1, and 0 holds.
- Issue load: when a slot issues with regwrite=1, cnt[rd] <= max(cnt[rd]-1 sat 0, LAT+BR_PENALTY), where LAT = LOAD_LAT if memread else ALU_LAT.
  - If both slots issue to the same rd, slot 1's value is used.
  - Issue update takes priority over decrement.
- Source hazard: a used source s in a normal instruction is blocked if cnt[s] > BR_PENALTY. A source of a branch is blocked if cnt[s] > 0.
- Intra-pair dependence: slot 1 is blocked if id_regwrite0 and id_rd0 matches a used slot-1 source.
- FSM states:
  - PAIR (reset state): both slots are still pending.
  - S1_ONLY: slot 0 of the held pair has already issued; slot 0 is treated as invalid.
- Decision in PAIR:
  - slot0 blocked → stall: pc_write=0, if_id_write=0, cntrl_sel0=1, cntrl_sel1=1; no scoreboard issue.
  - else if slot1 blocked → slot 0 issues (cntrl_sel0=0), cntrl_sel1=1, pc_write=0, if_id_write=0; next state S1_ONLY.
  - else → both issue; pc_write=1, if_id_write=1.
- Decision in S1_ONLY:
  - slot1 blocked → full stall, remain in S1_ONLY.
  - else → slot 1 issues, cntrl_sel0=1, pc_write=1, if_id_write=1; next state PAIR.
- An invalid slot is never blocked and never issues; its cntrl_sel is 1.
- flush=1 overrides everything:
  - cntrl_sel0=1, cntrl_sel1=1, no issue, pc_write=1, if_id_write=1, next state PAIR.
  - Scoreboard still decrements; stall_count does not increment.
- stall_count increments on every cycle with pc_write=0 and saturates at 16'hFFFF.
- Outputs are combinational from state, scoreboard and inputs; no added latency.
- Reset (asynchronous, any time):
  - all cnt=0, state=PAIR, stall_count=0.
  - Outputs then read pc_write=1, if_id_write=1, with cntrl_sel following id_valid.

Decomposition:
- Shared package hazard_pkg:
  - FSM state enum {PAIR, S1_ONLY}.
  - Function computing CNT_W.
  - Latency defaults.
- One sub-module, sb_counter: a single decrement/load/max counter, instantiated NUM_REGS times via generate.

Test Plan:
- Defaults. Load to r2 in slot 0, next pair slot 0 uses rm=r2 → one stall cycle (pc_write=0, stall_count=1), then issue.
- Slot 1 rn equals slot 0 rd=r5 (ALU) → cycle 1: cntrl_sel0=0, cntrl_sel1=1, pc_write=0; cycle 2 (S1_ONLY): cntrl_sel0=1, cntrl_sel1=0, pc_write=1.
- ALU writes r3, then branch reading r3 → branch stalls exactly BR_PENALTY=1 cycle. With ALU_LAT=0, a non-branch consumer does not stall.
- LOAD_LAT=3, load r1, then a consumer of r1 → 3 stall cycles; busy_vec[1]=1 for 4 cycles.
- In S1_ONLY with flush=1 → both cntrl_sel=1, pc_write=1, next state PAIR; a counter loaded with 2 still decrements to 1.
- Assert reset mid-stall (cnt[4]=2, S1_ONLY) → busy_vec=0, stall_count=0, state PAIR immediately, without waiting for a clock edge.
